// File: rtl/ctrl_pkg.sv
// Shared control definitions: opcode encodings, instruction field positions and the
// fetch sequencer state encoding, common to fetch and main control.
package ctrl_pkg;

   localparam logic [1:0] OP_LI  = 2'b00;
   localparam logic [1:0] OP_ADD = 2'b01;
   localparam logic [1:0] OP_ILL = 2'b10;
   localparam logic [1:0] OP_JMP = 2'b11;

   localparam int OPC_HI  = 7;
   localparam int OPC_LO  = 6;
   localparam int OPER_HI = 5;
   localparam int OPER_LO = 0;
   localparam int OPER_W  = OPER_HI - OPER_LO + 1;

   typedef enum logic [2:0] {
      FS_IDLE  = 3'd0,
      FS_REQ   = 3'd1,
      FS_WAIT  = 3'd2,
      FS_ISSUE = 3'd3,
      FS_HALT  = 3'd4
   } fetch_state_e;

endpackage

// File: rtl/instr_fetch_seq_if.sv
// Instruction memory read channel plus the issue channel towards decode.
interface instr_fetch_seq_if #(
   parameter int PC_W    = 8,
   parameter int INSTR_W = 8
) ();
   logic               imem_req;
   logic [PC_W-1:0]    imem_addr;
   logic               imem_ready;
   logic               imem_rvalid;
   logic [INSTR_W-1:0] imem_rdata;
   logic               instr_valid;
   logic [INSTR_W-1:0] instr;
   logic [1:0]         opcode;
   logic [PC_W-1:0]    instr_pc;
   logic               issue_ready;
   logic               jump_pc;

   modport master (
      output imem_req, imem_addr, instr_valid, instr, opcode, instr_pc,
      input  imem_ready, imem_rvalid, imem_rdata, issue_ready, jump_pc
   );

   modport slave (
      input  imem_req, imem_addr, instr_valid, instr, opcode, instr_pc,
      output imem_ready, imem_rvalid, imem_rdata, issue_ready, jump_pc
   );
endinterface

// File: rtl/instr_fetch_seq_pc_next_calc.sv
// Next-PC adder: sequential increment or sign-extended relative jump, modulo 2^PC_W.
module pc_next_calc #(
   parameter int PC_W  = 8,
   parameter int OFF_W = 6
) (
   input  logic [PC_W-1:0]  base,
   input  logic [OFF_W-1:0] offset,
   input  logic             jump,
   output logic [PC_W-1:0]  next_pc
);
   logic [PC_W-1:0] delta_s;

   // Select the PC delta; the sum wraps naturally at the PC width.
   always_comb begin
      delta_s = {{(PC_W-1){1'b0}}, 1'b1};
      if (jump) begin
         delta_s = {{(PC_W-OFF_W){offset[OFF_W-1]}}, offset};
      end else begin
         delta_s = {{(PC_W-1){1'b0}}, 1'b1};
      end
      next_pc = base + delta_s;
   end
endmodule

// File: rtl/instr_fetch_seq.sv
// Instruction fetch sequencer: single outstanding imem read, one held instruction
// presented to decode, PC redirect on JumpPC, sticky halt on the illegal opcode.
module instr_fetch_seq
   import ctrl_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter int              INSTR_W  = 8,
   parameter logic [PC_W-1:0] RESET_PC = {PC_W{1'b0}}
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              halted,
   instr_fetch_seq_if.master bus
);
   fetch_state_e       state_r;
   logic [PC_W-1:0]    pc_r;
   logic [PC_W-1:0]    imem_addr_r;
   logic [PC_W-1:0]    instr_pc_r;
   logic [INSTR_W-1:0] instr_r;
   logic               imem_req_r;
   logic               instr_valid_r;
   logic               halted_r;
   logic [PC_W-1:0]    pc_next_s;

   // Redirect target is relative to the held instruction's own address.
   pc_next_calc #(
      .PC_W  (PC_W),
      .OFF_W (OPER_W)
   ) u_pc_next (
      .base    (instr_pc_r),
      .offset  (instr_r[OPER_HI:OPER_LO]),
      .jump    (bus.jump_pc),
      .next_pc (pc_next_s)
   );

   // Fetch FSM with all bus-facing outputs registered.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r       <= FS_IDLE;
         pc_r          <= RESET_PC;
         imem_addr_r   <= RESET_PC;
         instr_pc_r    <= RESET_PC;
         instr_r       <= {INSTR_W{1'b0}};
         imem_req_r    <= 1'b0;
         instr_valid_r <= 1'b0;
         halted_r      <= 1'b0;
      end else begin
         case (state_r)
            FS_IDLE: begin
               if (start) begin
                  imem_req_r  <= 1'b1;
                  imem_addr_r <= pc_r;
                  state_r     <= FS_REQ;
               end
            end
            FS_REQ: begin
               if (bus.imem_ready) begin
                  imem_req_r <= 1'b0;
                  state_r    <= FS_WAIT;
               end
            end
            FS_WAIT: begin
               if (bus.imem_rvalid) begin
                  instr_r       <= bus.imem_rdata;
                  instr_pc_r    <= pc_r;
                  instr_valid_r <= 1'b1;
                  state_r       <= FS_ISSUE;
               end
            end
            FS_ISSUE: begin
               if (bus.issue_ready) begin
                  instr_valid_r <= 1'b0;
                  if (instr_r[OPC_HI:OPC_LO] == OP_ILL) begin
                     halted_r <= 1'b1;
                     state_r  <= FS_HALT;
                  end else begin
                     pc_r        <= pc_next_s;
                     imem_addr_r <= pc_next_s;
                     imem_req_r  <= 1'b1;
                     state_r     <= FS_REQ;
                  end
               end
            end
            FS_HALT: begin
               imem_req_r    <= 1'b0;
               instr_valid_r <= 1'b0;
            end
            default: begin
               imem_req_r    <= 1'b0;
               instr_valid_r <= 1'b0;
               state_r       <= FS_IDLE;
            end
         endcase
      end
   end

   assign bus.imem_req    = imem_req_r;
   assign bus.imem_addr   = imem_addr_r;
   assign bus.instr_valid = instr_valid_r;
   assign bus.instr       = instr_r;
   assign bus.opcode      = instr_r[OPC_HI:OPC_LO];
   assign bus.instr_pc    = instr_pc_r;
   assign halted          = halted_r;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Directed bench for instr_fetch_seq: the bench plays instruction memory and decode,
// queues each accepted fetch as an expected issue, and checks it at the issue handshake.
module tb_instr_fetch_seq;
   logic clk = 1'b0;
   logic rst;
   logic start;
   logic halted;

   instr_fetch_seq_if #(.PC_W(8), .INSTR_W(8)) bus ();

   instr_fetch_seq #(
      .PC_W     (8),
      .INSTR_W  (8),
      .RESET_PC (8'h00)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .halted (halted),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int last_issue = 0;
   int prev_issue = 0;
   logic [15:0] sb_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One complete fetch/issue transaction with optional stalls on each handshake.
   task automatic fetch(input logic [7:0] addr, input logic [7:0] data, input int rdy_dly,
                        input int rv_dly, input int iss_dly, input logic jmp);
      logic [15:0] e;
      chk("req_high", 32'(bus.imem_req), 32'd1);
      chk("req_addr", 32'(bus.imem_addr), 32'(addr));
      for (int i = 0; i < rdy_dly; i++) begin
         bus.imem_ready = 1'b0;
         start = 1'b1;
         tick();
         chk("req_hold", 32'(bus.imem_req), 32'd1);
         chk("addr_hold", 32'(bus.imem_addr), 32'(addr));
      end
      start = 1'b0;
      bus.imem_ready = 1'b1;
      tick();
      bus.imem_ready = 1'b0;
      sb_q.push_back({data, addr});
      chk("wait_req_low", 32'(bus.imem_req), 32'd0);
      for (int i = 0; i < rv_dly; i++) begin
         tick();
         chk("wait_no_req", 32'(bus.imem_req), 32'd0);
         chk("wait_no_valid", 32'(bus.instr_valid), 32'd0);
      end
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = data;
      tick();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 8'h00;
      chk("issue_valid", 32'(bus.instr_valid), 32'd1);
      for (int i = 0; i < iss_dly; i++) begin
         bus.issue_ready = 1'b0;
         bus.jump_pc = ~jmp;
         tick();
         chk("stall_instr", 32'(bus.instr), 32'(data));
         chk("stall_pc", 32'(bus.instr_pc), 32'(addr));
         chk("stall_valid", 32'(bus.instr_valid), 32'd1);
         chk("stall_no_req", 32'(bus.imem_req), 32'd0);
      end
      if (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         chk("sb_instr", 32'(bus.instr), 32'(e[15:8]));
         chk("sb_instr_pc", 32'(bus.instr_pc), 32'(e[7:0]));
         chk("sb_opcode", 32'(bus.opcode), 32'(e[15:14]));
      end
      bus.jump_pc = jmp;
      bus.issue_ready = 1'b1;
      prev_issue = last_issue;
      tick();
      last_issue = cyc;
      bus.issue_ready = 1'b0;
      bus.jump_pc = 1'b0;
      chk("post_issue_valid", 32'(bus.instr_valid), 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      start = 1'b0;
      bus.imem_ready = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 8'h00;
      bus.issue_ready = 1'b0;
      bus.jump_pc = 1'b0;
      #12;
      chk("rst_req", 32'(bus.imem_req), 32'd0);
      chk("rst_valid", 32'(bus.instr_valid), 32'd0);
      chk("rst_addr", 32'(bus.imem_addr), 32'h00);
      chk("rst_instr_pc", 32'(bus.instr_pc), 32'h00);
      chk("rst_instr", 32'(bus.instr), 32'h00);
      chk("rst_halted", 32'(halted), 32'd0);

      tick();
      rst = 1'b1;
      tick();
      chk("idle_req", 32'(bus.imem_req), 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;

      // Straight line, zero wait: issues three cycles apart.
      fetch(8'h00, 8'h41, 0, 0, 0, 1'b0);
      fetch(8'h01, 8'h05, 0, 0, 0, 1'b0);
      chk("throughput", 32'(last_issue - prev_issue), 32'd3);

      // Asynchronous reset while waiting for read data at pc 2.
      chk("pre_rst_addr", 32'(bus.imem_addr), 32'h02);
      bus.imem_ready = 1'b1;
      tick();
      bus.imem_ready = 1'b0;
      chk("pre_rst_wait", 32'(bus.imem_req), 32'd0);
      #3;
      rst = 1'b0;
      #1;
      chk("async_req", 32'(bus.imem_req), 32'd0);
      chk("async_valid", 32'(bus.instr_valid), 32'd0);
      chk("async_addr", 32'(bus.imem_addr), 32'h00);
      chk("async_instr_pc", 32'(bus.instr_pc), 32'h00);
      chk("async_halted", 32'(halted), 32'd0);
      tick();
      rst = 1'b1;
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata = 8'hAA;
      tick();
      tick();
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata = 8'h00;
      chk("stray_valid", 32'(bus.instr_valid), 32'd0);
      chk("stray_instr", 32'(bus.instr), 32'h00);
      chk("stray_req", 32'(bus.imem_req), 32'd0);

      start = 1'b1;
      tick();
      start = 1'b0;
      fetch(8'h00, 8'h00, 0, 0, 0, 1'b0);
      fetch(8'h01, 8'h40, 0, 0, 0, 1'b0);
      fetch(8'h02, 8'h41, 0, 1, 0, 1'b0);
      fetch(8'h03, 8'h42, 1, 0, 0, 1'b0);
      // Relative jumps forward +3 and back -4.
      fetch(8'h04, 8'hC3, 0, 0, 0, 1'b1);
      fetch(8'h07, 8'hFC, 0, 0, 0, 1'b1);
      // Stalls on every handshake; start and jump_pc toggled while stalled.
      fetch(8'h03, 8'h55, 3, 2, 4, 1'b0);
      fetch(8'h04, 8'hFB, 0, 0, 0, 1'b1);
      fetch(8'hFF, 8'h7F, 0, 0, 0, 1'b1);
      fetch(8'hFE, 8'h01, 0, 0, 0, 1'b0);
      fetch(8'hFF, 8'h02, 0, 0, 0, 1'b0);
      fetch(8'h00, 8'hE0, 0, 0, 0, 1'b1);
      chk("pre_halt", 32'(halted), 32'd0);
      fetch(8'hE0, 8'h80, 0, 0, 1, 1'b1);
      chk("halted", 32'(halted), 32'd1);
      chk("halt_req", 32'(bus.imem_req), 32'd0);

      start = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("halt_no_req", 32'(bus.imem_req), 32'd0);
         chk("halt_no_valid", 32'(bus.instr_valid), 32'd0);
         chk("halt_sticky", 32'(halted), 32'd1);
      end
      start = 1'b0;

      #2;
      rst = 1'b0;
      #1;
      chk("halt_cleared", 32'(halted), 32'd0);
      chk("halt_rst_addr", 32'(bus.imem_addr), 32'h00);
      tick();
      rst = 1'b1;
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
